// File: rtl/xt_hb2lb_bridge_pkg.sv
// XT_BUS: shared HB/LB bus types and the HB-to-LB bridge state encoding.
package XT_BUS;

    localparam int HB_ADDR_WIDTH   = 20;  // [19:16] slot ID, [15:0] offset
    localparam int HB_OFFSET_WIDTH = 16;
    localparam int LB_ADDR_WIDTH   = 8;
    localparam int DATA_WIDTH      = 32;
    localparam int WW_WIDTH        = 2;

    // System default LB read latency (cycles from ren strobe to valid rdata).
    localparam int LB_RD_LATENCY   = 1;

    typedef struct packed {
        logic [HB_ADDR_WIDTH-1:0] raddr;
        logic [HB_ADDR_WIDTH-1:0] waddr;
        logic [DATA_WIDTH-1:0]    wdata;
        logic [WW_WIDTH-1:0]      write_width;
    } hb_slave_t;

    typedef struct packed {
        logic ren;
        logic wen;
    } sel_t;

    typedef struct packed {
        logic                     ren;
        logic                     wen;
        logic [LB_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    wdata;
        logic [WW_WIDTH-1:0]      write_width;
    } lb_slave_t;

    typedef enum logic [2:0] {IDLE, WRITE, READ, RWAIT, ACK} hb2lb_state_e;

    // An HB offset that does not fit in LB space.
    function automatic logic off_err(input logic [HB_ADDR_WIDTH-1:0] a);
        return |a[HB_OFFSET_WIDTH-1:LB_ADDR_WIDTH];
    endfunction

endpackage

// File: rtl/xt_hb2lb_bridge_if.sv
// HB slave slot plus LB master side of the bridge, bundled as one interface.
interface xt_hb2lb_bridge_if;
    import XT_BUS::*;

    hb_slave_t              hb;
    sel_t                   hb_sel;
    logic [DATA_WIDTH-1:0]  hb_rdata;
    logic                   hb_stall;
    lb_slave_t              lb;
    logic [DATA_WIDTH-1:0]  lb_rdata;
    logic                   addr_err;

    // Bridge view.
    modport slave (
        input  hb, hb_sel, lb_rdata,
        output hb_rdata, hb_stall, lb, addr_err
    );

    // Environment view: HB master and LB peripheral mux.
    modport master (
        output hb, hb_sel, lb_rdata,
        input  hb_rdata, hb_stall, lb, addr_err
    );
endinterface

// File: rtl/xt_hb2lb_bridge.sv
// HB slave to LB master bridge: turns one HB request (write, read, or both)
// into single-cycle LB strobes, stalling HB until a one-cycle ACK.
module xt_hb2lb_bridge
    import XT_BUS::*;
#(
    parameter int RD_LATENCY = LB_RD_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    xt_hb2lb_bridge_if.slave  bus
);

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_lat
        $error("xt_hb2lb_bridge: RD_LATENCY must be in 1..4");
    end

    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    hb2lb_state_e             state_q, state_d;
    logic [2:0]               cnt_q, cnt_d;
    logic [LB_ADDR_WIDTH-1:0] raddr_q, raddr_d;
    sel_t                     sel_q, sel_d;
    logic                     rerr_q, rerr_d;
    logic                     werr_q, werr_d;
    lb_slave_t                lb_q, lb_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     aerr_q, aerr_d;

    // Slot ID bits are decoded upstream and deliberately ignored here.
    logic unused_id;
    assign unused_id = ^{bus.hb.raddr[HB_ADDR_WIDTH-1:HB_OFFSET_WIDTH],
                         bus.hb.waddr[HB_ADDR_WIDTH-1:HB_OFFSET_WIDTH]};

    assign bus.hb_stall = (bus.hb_sel.ren | bus.hb_sel.wen) & (state_q != ACK);
    assign bus.lb       = lb_q;
    assign bus.hb_rdata = rdata_q;
    assign bus.addr_err = aerr_q;

    // Next state, registered LB strobes, read capture and error pulse.
    // The write fields go straight into lb_q at acceptance, so only the read
    // address needs its own latch for the write-then-read case.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        raddr_d = raddr_q;
        sel_d   = sel_q;
        rerr_d  = rerr_q;
        werr_d  = werr_q;
        lb_d    = lb_q;
        lb_d.ren = 1'b0;
        lb_d.wen = 1'b0;
        rdata_d = rdata_q;
        aerr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.hb_sel.ren || bus.hb_sel.wen) begin
                    sel_d   = bus.hb_sel;
                    raddr_d = bus.hb.raddr[LB_ADDR_WIDTH-1:0];
                    rerr_d  = off_err(bus.hb.raddr);
                    werr_d  = off_err(bus.hb.waddr);
                    if (bus.hb_sel.wen) begin
                        state_d = WRITE;
                        if (!werr_d) begin
                            lb_d.wen         = 1'b1;
                            lb_d.addr        = bus.hb.waddr[LB_ADDR_WIDTH-1:0];
                            lb_d.wdata       = bus.hb.wdata;
                            lb_d.write_width = bus.hb.write_width;
                        end
                    end else begin
                        state_d = READ;
                        if (!rerr_d) begin
                            lb_d.ren  = 1'b1;
                            lb_d.addr = bus.hb.raddr[LB_ADDR_WIDTH-1:0];
                        end
                    end
                end
            end
            WRITE: begin
                if (sel_q.ren) begin
                    state_d = READ;
                    if (!rerr_q) begin
                        lb_d.ren  = 1'b1;
                        lb_d.addr = raddr_q;
                    end
                end else begin
                    state_d = ACK;
                    aerr_d  = werr_q;
                end
            end
            READ: begin
                state_d = RWAIT;
                cnt_d   = 3'd1;
            end
            RWAIT: begin
                if (cnt_q == LAT) begin
                    state_d = ACK;
                    rdata_d = rerr_q ? '0 : bus.lb_rdata;
                    aerr_d  = rerr_q | (sel_q.wen & werr_q);
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops strobes and the pending request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            raddr_q <= '0;
            sel_q   <= '0;
            rerr_q  <= 1'b0;
            werr_q  <= 1'b0;
            lb_q    <= '0;
            rdata_q <= '0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            raddr_q <= raddr_d;
            sel_q   <= sel_d;
            rerr_q  <= rerr_d;
            werr_q  <= werr_d;
            lb_q    <= lb_d;
            rdata_q <= rdata_d;
            aerr_q  <= aerr_d;
        end
    end

endmodule

// File: tb/tb_xt_hb2lb_bridge.sv
// Directed bench for xt_hb2lb_bridge: u1 uses RD_LATENCY=1, u3 uses 3.
module tb_xt_hb2lb_bridge;
    import XT_BUS::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    xt_hb2lb_bridge_if b1();
    xt_hb2lb_bridge_if b3();

    xt_hb2lb_bridge #(.RD_LATENCY(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    xt_hb2lb_bridge #(.RD_LATENCY(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

    // Peripheral model: data valid exactly RD_LATENCY cycles after ren.
    logic [31:0] pdata = 32'h1234_5678;
    logic [3:0]  rp1 = '0;
    logic [3:0]  rp3 = '0;
    always @(posedge clk) begin
        rp1 <= {rp1[2:0], b1.lb.ren};
        rp3 <= {rp3[2:0], b3.lb.ren};
    end
    assign b1.lb_rdata = rp1[0] ? pdata : 32'hBAD0_BAD0;
    assign b3.lb_rdata = rp3[2] ? pdata : 32'hBAD0_BAD0;

    int npass  = 0;
    int ntotal = 0;
    int nw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        b1.hb = '0; b1.hb_sel = '0;
        b3.hb = '0; b3.hb_sel = '0;

        // Reset state
        #3;
        chk("rst_wen",    32'(b1.lb.wen), 0);
        chk("rst_ren",    32'(b1.lb.ren), 0);
        chk("rst_rdata",  b1.hb_rdata, 0);
        chk("rst_stall",  32'(b1.hb_stall), 0);
        chk("rst_aerr",   32'(b1.addr_err), 0);
        chk("rst3_rdata", b3.hb_rdata, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Write: 3 cycles, strobe in cycle 1
        b1.hb.waddr = 20'h00010; b1.hb.wdata = 32'hDEAD_BEEF; b1.hb.write_width = 2'd2;
        b1.hb_sel.wen = 1'b1;
        #1;
        chk("wr_c0_stall", 32'(b1.hb_stall), 1);
        tick();
        chk("wr_c1_wen",   32'(b1.lb.wen), 1);
        chk("wr_c1_addr",  32'(b1.lb.addr), 32'h10);
        chk("wr_c1_wdata", b1.lb.wdata, 32'hDEAD_BEEF);
        chk("wr_c1_ww",    32'(b1.lb.write_width), 2);
        chk("wr_c1_stall", 32'(b1.hb_stall), 1);
        tick();
        chk("wr_c2_stall", 32'(b1.hb_stall), 0);
        chk("wr_c2_wen",   32'(b1.lb.wen), 0);
        chk("wr_c2_addr",  32'(b1.lb.addr), 32'h10);
        b1.hb_sel = '0;
        tick();
        chk("wr_rdata_kept", b1.hb_rdata, 0);

        // Read on both instances (latency 1 and 3)
        b1.hb.raddr = 20'h00024; b3.hb.raddr = 20'h00024;
        b1.hb_sel.ren = 1'b1;    b3.hb_sel.ren = 1'b1;
        #1;
        chk("rd_c0_stall", 32'(b1.hb_stall), 1);
        tick();
        chk("rd_c1_ren",   32'(b1.lb.ren), 1);
        chk("rd_c1_addr",  32'(b1.lb.addr), 32'h24);
        chk("rd3_c1_ren",  32'(b3.lb.ren), 1);
        tick();
        chk("rd_c2_ren",   32'(b1.lb.ren), 0);
        chk("rd_c2_stall", 32'(b1.hb_stall), 1);
        tick();
        chk("rd_c3_stall", 32'(b1.hb_stall), 0);
        chk("rd_c3_rdata", b1.hb_rdata, 32'h1234_5678);
        chk("rd3_c3_stall", 32'(b3.hb_stall), 1);
        b1.hb_sel = '0;
        tick();
        chk("rd3_c4_stall", 32'(b3.hb_stall), 1);
        tick();
        chk("rd3_c5_stall", 32'(b3.hb_stall), 0);
        chk("rd3_c5_rdata", b3.hb_rdata, 32'h1234_5678);
        b3.hb_sel = '0;
        tick();

        // Combined write then read, single ACK
        pdata = 32'hA5A5_0F0F;
        b1.hb.waddr = 20'h00004; b1.hb.raddr = 20'h00008;
        b1.hb.wdata = 32'hCAFE_F00D; b1.hb.write_width = 2'd1;
        b1.hb_sel = '{ren: 1'b1, wen: 1'b1};
        tick();
        chk("cb_c1_wen",  32'(b1.lb.wen), 1);
        chk("cb_c1_ren",  32'(b1.lb.ren), 0);
        chk("cb_c1_addr", 32'(b1.lb.addr), 32'h04);
        tick();
        chk("cb_c2_ren",  32'(b1.lb.ren), 1);
        chk("cb_c2_wen",  32'(b1.lb.wen), 0);
        chk("cb_c2_addr", 32'(b1.lb.addr), 32'h08);
        tick();
        chk("cb_c3_stall", 32'(b1.hb_stall), 1);
        tick();
        chk("cb_c4_stall", 32'(b1.hb_stall), 0);
        chk("cb_c4_rdata", b1.hb_rdata, 32'hA5A5_0F0F);
        b1.hb_sel = '0;
        tick();

        // Read beyond LB space: no strobe, zero data, addr_err in ACK only
        b1.hb.raddr = 20'h001A0;
        b1.hb_sel.ren = 1'b1;
        tick();
        chk("ae_c1_ren",  32'(b1.lb.ren), 0);
        chk("ae_c1_addr", 32'(b1.lb.addr), 32'h08);
        tick();
        chk("ae_c2_aerr", 32'(b1.addr_err), 0);
        tick();
        chk("ae_c3_stall", 32'(b1.hb_stall), 0);
        chk("ae_c3_aerr",  32'(b1.addr_err), 1);
        chk("ae_c3_rdata", b1.hb_rdata, 0);
        b1.hb_sel = '0;
        tick();
        chk("ae_c4_aerr", 32'(b1.addr_err), 0);

        // Slot ID bits ignored
        pdata = 32'h0BAD_CAFE ^ 32'h0000_0001;
        b1.hb.raddr = 20'hF0030;
        b1.hb_sel.ren = 1'b1;
        tick();
        chk("id_c1_ren",  32'(b1.lb.ren), 1);
        chk("id_c1_addr", 32'(b1.lb.addr), 32'h30);
        tick(); tick();
        chk("id_c3_aerr",  32'(b1.addr_err), 0);
        chk("id_c3_rdata", b1.hb_rdata, 32'h0BAD_CAFF);
        b1.hb_sel = '0;
        tick();

        // Held write request: two separate transactions, two wen pulses
        nw = 0;
        b1.hb.waddr = 20'h00020; b1.hb.wdata = 32'h1111_2222;
        b1.hb_sel.wen = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 4) b1.hb_sel = '0;
            if (b1.lb.wen) nw++;
            if (c == 2) begin
                chk("hold_c2_wen",   32'(b1.lb.wen), 0);
                chk("hold_c2_stall", 32'(b1.hb_stall), 0);
            end
            if (c == 3) begin
                chk("hold_c3_wen",   32'(b1.lb.wen), 0);
                chk("hold_c3_stall", 32'(b1.hb_stall), 1);
            end
            if (c == 4) chk("hold_c4_wen", 32'(b1.lb.wen), 1);
        end
        chk("hold_pulses", 32'(nw), 2);
        chk("hold_rdata_kept", b1.hb_rdata, 32'h0BAD_CAFF);

        // Reset in the middle of a write
        b1.hb.waddr = 20'h00040; b1.hb.wdata = 32'h55AA_55AA;
        b1.hb_sel.wen = 1'b1;
        tick();
        chk("mr_c1_wen", 32'(b1.lb.wen), 1);
        #2 rst = 1'b1;
        #1;
        chk("mr_wen_drop", 32'(b1.lb.wen), 0);
        chk("mr_stall_idle", 32'(b1.hb_stall), 1);
        b1.hb_sel = '0;
        #1;
        chk("mr_stall", 32'(b1.hb_stall), 0);
        chk("mr_rdata", b1.hb_rdata, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("mr_post_wen", 32'(b1.lb.wen), 0);
        chk("mr_post_ren", 32'(b1.lb.ren), 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
